// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the convolutional-encoder frame scheduler.
// Used by conv_rr_arbiter and conv_frame_scheduler.
package conv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TAIL  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  // (2,1,3) code: two flip-flops of encoder memory, so two flush bits.
  localparam int DEFAULT_MEM_LEN = 2;

  // Width needed to hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_rr_arbiter.sv
// Round-robin one-hot picker: chooses the first asserted request strictly
// after the pointer index, wrapping around, so the last winner has lowest
// priority on the next pick.
module conv_rr_arbiter
  import conv_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [GW-1:0]      gid,
  output logic               any
);

  // Scan offsets 1..NUM_REQ from the pointer and take the first hit.
  always_comb begin
    int idx;
    grant = '0;
    gid   = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        gid        = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/conv_frame_scheduler.sv
// Shares one (2,1,3) convolutional encoder among NUM_REQ frame sources.
// A round-robin grant loads one parallel frame, which is shifted out MSB
// first, optionally followed by MEM_LEN zero tail bits, then a one-cycle
// enc_clear.
// Build option: define CONV_TAIL_EN to append the zero tail bits; without
// it the encoder is flushed by enc_clear alone.
module conv_frame_scheduler
  import conv_sched_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int FRAME_LEN = 8,
  parameter int MEM_LEN   = DEFAULT_MEM_LEN,
  localparam int GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*FRAME_LEN-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         enc_ready,
  output logic                         enc_bit,
  output logic                         enc_valid,
  output logic                         enc_sof,
  output logic                         enc_eof,
  output logic                         enc_clear,
  output logic [GW-1:0]                grant_id,
  output logic                         busy
);

  // Counter covers both the data phase and the tail phase.
  localparam int CNT_W = cnt_width(((FRAME_LEN > MEM_LEN) ? FRAME_LEN : MEM_LEN) + 1);

  state_t                 state_q, state_d;
  logic [FRAME_LEN-1:0]   shreg_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [GW-1:0]          gid_q;
  logic [GW-1:0]          ptr_q;

  logic [NUM_REQ-1:0]     arb_grant;
  logic [GW-1:0]          arb_gid;
  logic                   arb_any;
  logic [FRAME_LEN-1:0]   frame_sel;
  logic                   data_last;
  logic                   load;

  conv_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .gid   (arb_gid),
    .any   (arb_any)
  );

  assign data_last = (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign load      = (state_q == IDLE) && arb_any;

  // Select the winning requester's frame slice.
  always_comb begin
    frame_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gid == GW'(i)) frame_sel = req_data[i*FRAME_LEN +: FRAME_LEN];
    end
  end

  // Next-state logic and the handshake/stream outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    enc_valid = 1'b0;
    enc_bit   = 1'b0;
    enc_sof   = 1'b0;
    enc_eof   = 1'b0;
    enc_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any && !reset) begin
          req_ready = arb_grant;
          state_d   = DATA;
        end
      end
      DATA: begin
        enc_valid = 1'b1;
        enc_bit   = shreg_q[FRAME_LEN-1];
        enc_sof   = (cnt_q == '0);
`ifdef CONV_TAIL_EN
        if (enc_ready && data_last) state_d = TAIL;
`else
        enc_eof   = data_last;
        if (enc_ready && data_last) state_d = CLEAR;
`endif
      end
      TAIL: begin
`ifdef CONV_TAIL_EN
        enc_valid = 1'b1;
        enc_eof   = (cnt_q == CNT_W'(MEM_LEN - 1));
        if (enc_ready && enc_eof) state_d = CLEAR;
`else
        state_d   = CLEAR;
`endif
      end
      CLEAR: begin
        enc_clear = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_id = gid_q;
  assign busy     = (state_q != IDLE);

  // Control state: FSM, bit counter, grant id and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gid_q   <= '0;
      ptr_q   <= GW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      if (load) begin
        cnt_q <= '0;
        gid_q <= arb_gid;
        ptr_q <= arb_gid;
      end else if (enc_valid && enc_ready) begin
        cnt_q <= (state_q == DATA && data_last) ? '0 : cnt_q + 1'b1;
      end
    end
  end

  // Frame shift register: parallel load on grant, shift on each accepted bit.
  always_ff @(posedge clk) begin
    if (load) begin
      shreg_q <= frame_sel;
    end else if (state_q == DATA && enc_ready) begin
      shreg_q <= {shreg_q[FRAME_LEN-2:0], 1'b0};
    end
  end

endmodule
